// File: rtl/scrambler_pkg.sv
// Shared definitions for the x^7+x^6+1 self-synchronising scrambler pair.
package scrambler_pkg;

  localparam int LFSR_LEN = 7;
  localparam int TAP_A    = 5;
  localparam int TAP_B    = 6;

  // Fill count value seen on the accept that completes the shift register.
  localparam logic [2:0] FILL_LAST = 3'(LFSR_LEN - 1);

  typedef enum logic {
    FILL   = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

  // Tap XOR shared by scrambler and descrambler: y ^ s[5] ^ s[6].
  function automatic logic tap_xor(input logic y, input logic [LFSR_LEN-1:0] s);
    return y ^ s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/xor_descrambler_if.sv
// Serial bit stream in, descrambled bit stream plus status out.
interface xor_descrambler_if #(
  parameter int CNT_W = 16
);
  logic             input1;
  logic             in_valid;
  logic             flush;
  logic             output1;
  logic             out_valid;
  logic             locked;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output input1, in_valid, flush,
    input  output1, out_valid, locked, bit_count
  );

  modport slave (
    input  input1, in_valid, flush,
    output output1, out_valid, locked, bit_count
  );
endinterface

// File: rtl/xor_descrambler_shift_reg.sv
// Received-bit history and tap XOR. The register stores the line bit y,
// never the descrambled bit, which is what makes the descrambler self-sync.
module descr_shift_reg
  import scrambler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic clr,
  input  logic y,
  output logic d
);

  logic [LFSR_LEN-1:0] s;

  // s[0] newest, s[LFSR_LEN-1] oldest; clear wins over shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          s <= '0;
    else if (clr)      s <= '0;
    else if (shift_en) s <= {s[LFSR_LEN-2:0], y};
  end

  assign d = tap_xor(y, s);

endmodule

// File: rtl/xor_descrambler.sv
// Self-synchronising descrambler: fills 7 line bits, then emits one
// descrambled bit per accepted line bit with one cycle of latency.
module xor_descrambler
  import scrambler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  xor_descrambler_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sync_state_t      state, state_nxt;
  logic [2:0]       fill_cnt, fill_nxt;
  logic             accept, emit, d;
  logic             out_bit, out_vld;
  logic [CNT_W-1:0] cnt;

  // Flush drops a coincident bit, so it never counts as an accept.
  assign accept = bus.in_valid & ~bus.flush;
  assign emit   = accept & (state == LOCKED);

  descr_shift_reg u_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (bus.flush),
    .y        (bus.input1),
    .d        (d)
  );

  // State and fill counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
    end
  end

  // Next state: the accept completing the fill locks on the same edge.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    if (bus.flush) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else begin
      case (state)
        FILL: if (accept) begin
          fill_nxt = fill_cnt + 3'd1;
          if (fill_cnt == FILL_LAST) state_nxt = LOCKED;
        end
        LOCKED: ;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Output register: one-cycle valid pulse per locked accept, data held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_bit <= 1'b0;
      out_vld <= 1'b0;
    end else if (bus.flush) begin
      out_bit <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= emit;
      if (emit) out_bit <= d;
    end
  end

  // Saturating count of emitted bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (bus.flush)              cnt <= '0;
    else if (emit && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  assign bus.output1   = out_bit;
  assign bus.out_valid = out_vld;
  assign bus.locked    = (state == LOCKED);
  assign bus.bit_count = cnt;

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler; a second instance with CNT_W=3
// exercises counter saturation.
module tb_xor_descrambler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  xor_descrambler_if #(.CNT_W(16)) bus  ();
  xor_descrambler_if #(.CNT_W(3))  bus3 ();

  xor_descrambler #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  xor_descrambler #(.CNT_W(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One accepted bit on the main instance; returns #1 after the edge.
  task automatic acc(input logic b);
    bus.in_valid = 1'b1;
    bus.input1   = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic acc3(input logic b);
    bus3.in_valid = 1'b1;
    bus3.input1   = b;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  logic [6:0]  sc;
  logic [15:0] data;
  logic        y;

  initial begin
    bus.input1 = 0;  bus.in_valid = 0;  bus.flush = 0;
    bus3.input1 = 0; bus3.in_valid = 0; bus3.flush = 0;

    // Reset state
    #12;
    chk("rst_outs", {bus.output1, bus.out_valid, bus.locked}, 3'b000);
    chk("rst_cnt", bus.bit_count, 0);
    #5 rst = 1'b1;  // released between edges (t=17)
    #1;

    // Seven ones fill without output; lock after the 7th
    for (int i = 0; i < 7; i++) begin
      acc(1'b1);
      chk("fill_noval", bus.out_valid, 0);
      if (i == 5) chk("fill6_unlocked", bus.locked, 0);
    end
    chk("locked_after7", bus.locked, 1);
    acc(1'b1);
    chk("b8_out", {bus.out_valid, bus.output1}, 2'b11);
    chk("b8_cnt", bus.bit_count, 1);
    acc(1'b0);
    chk("b9_out", {bus.out_valid, bus.output1}, 2'b10);
    chk("b9_cnt", bus.bit_count, 2);

    // Gapped accepts 1,0,0,1 (input bits 1 then 0)
    acc(1'b1);
    chk("gap_a0", {bus.out_valid, bus.output1}, 2'b11);
    idle();
    chk("gap_i1", {bus.out_valid, bus.output1}, 2'b01);
    idle();
    chk("gap_i2", {bus.out_valid, bus.output1}, 2'b01);
    acc(1'b0);
    chk("gap_a3", {bus.out_valid, bus.output1}, 2'b10);
    chk("gap_cnt", bus.bit_count, 4);

    // Flush with a coincident valid bit: bit is dropped
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.input1 = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_outs", {bus.locked, bus.out_valid, bus.output1}, 3'b000);
    chk("fl_cnt", bus.bit_count, 0);
    for (int i = 0; i < 6; i++) acc(1'b0);
    chk("fl_6_unlocked", bus.locked, 0);
    acc(1'b0);
    chk("fl_7_locked", bus.locked, 1);

    // Loopback through a reference scrambler, seed 7'h5A
    do_flush();
    sc   = 7'h5A;
    data = 16'hA53C;
    for (int i = 0; i < 7; i++) begin
      y  = 1'b0 ^ sc[5] ^ sc[6];
      sc = {sc[5:0], y};
      acc(y);
      chk("lb_fill", bus.out_valid, 0);
    end
    chk("lb_locked", bus.locked, 1);
    for (int i = 15; i >= 0; i--) begin
      y  = data[i] ^ sc[5] ^ sc[6];
      sc = {sc[5:0], y};
      acc(y);
      chk("lb_bit", {bus.out_valid, bus.output1}, {1'b1, data[i]});
    end
    chk("lb_cnt", bus.bit_count, 16);

    // Saturation on the CNT_W=3 instance
    for (int i = 0; i < 7; i++) acc3(1'b0);
    chk("sat_locked", bus3.locked, 1);
    for (int i = 0; i < 9; i++) begin
      acc3(1'b0);
      if (i == 6) chk("sat_at7", bus3.bit_count, 7);
    end
    chk("sat_hold", {bus3.out_valid, bus3.bit_count}, 4'b1111);

    // Async reset mid-fill on main instance, with the small one locked
    do_flush();
    for (int i = 0; i < 4; i++) acc(1'b1);
    bus3.in_valid = 1'b1;  // pending accept on small instance
    #2 rst = 1'b0;
    #1;
    chk("arst_main", {bus.output1, bus.out_valid, bus.locked, bus.bit_count}, 19'd0);
    chk("arst_small", {bus3.output1, bus3.out_valid, bus3.locked, bus3.bit_count}, 6'd0);
    bus3.in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) acc(1'b1);
    chk("arst_6_unlocked", bus.locked, 0);
    acc(1'b1);
    chk("arst_7_locked", bus.locked, 1);
    acc(1'b1);
    chk("arst_first_out", {bus.out_valid, bus.output1, bus.bit_count}, 18'h30001);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
